// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8-bit UART receiver with start-bit glitch rejection, framing
//               and break detection. Optional even parity via UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int unsigned BIT_CYCLES = 2605
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned c_HALF      = BIT_CYCLES / 2;
    localparam logic [12:0] c_BIT_LAST  = 13'(BIT_CYCLES - 1);
    localparam logic [12:0] c_HALF_LAST = 13'(c_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic [12:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_parity_err;
`ifdef UART_RX_PARITY_EN
    logic        r_parity_bit;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_cnt        <= 13'd0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            data         <= 8'h00;
            valid        <= 1'b0;
            frame_err    <= 1'b0;
            r_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bit <= 1'b0;
`endif
        end else begin
            r_rx_meta    <= rx;
            r_rx_s       <= r_rx_meta;
            valid        <= 1'b0;
            frame_err    <= 1'b0;
            r_parity_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt     <= 13'd0;
                    r_bit_idx <= 3'd0;
                    if (!r_rx_s) r_state <= S_START;
                end

                // Re-check the line at mid start bit so short glitches are dropped.
                S_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt     <= 13'd0;
                        r_bit_idx <= 3'd0;
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end

                S_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt     <= 13'd0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt        <= 13'd0;
                        r_parity_bit <= r_rx_s;
                        r_state      <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end
`endif

                S_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt <= 13'd0;
                        if (r_rx_s) begin
                            data    <= r_shift;
                            valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= ^{r_shift, r_parity_bit};
`endif
                            r_state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end

                // A break holds the line low; wait it out so it reports only once.
                S_WAIT_HIGH: begin
                    r_cnt <= 13'd0;
                    if (r_rx_s) r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed, table-driven bench for uart_rx at a short bit time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int B = 16;
    localparam int H = B / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    localparam int LAT = 3 + H + NBITS * B;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;

    uart_rx #(.BIT_CYCLES(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int         valid_cnt   = 0;
    int         ferr_cnt    = 0;
    int         perr_cnt    = 0;
    int         overlap_cnt = 0;
    int         stray_perr  = 0;
    logic [7:0] got[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin
                valid_cnt = valid_cnt + 1;
                got.push_back(data);
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (parity_err) perr_cnt = perr_cnt + 1;
            if (valid && frame_err) overlap_cnt = overlap_cnt + 1;
            if (parity_err && !valid) stray_perr = stray_perr + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    logic tx_par = 1'b0;
`endif

    // Caller must be at a negedge; line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        idle(B);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(B);
        end
`ifdef UART_RX_PARITY_EN
        rx = tx_par;
        idle(B);
`endif
        rx = stop;
        idle(B);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par;
        int         exp_perr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int v0, f0, p0, k;
        logic [7:0] prev;

        vecs.push_back('{8'h55, 1'b0, 0});
        vecs.push_back('{8'h3C, 1'b0, 0});
        vecs.push_back('{8'hA5, 1'b0, 0});
        vecs.push_back('{8'h01, 1'b1, 0});
        vecs.push_back('{8'h80, 1'b1, 0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b0, 1});
        vecs.push_back('{8'h07, 1'b1, 0});
`endif

        // Reset state
        reset = 1'b1;
        rx    = 1'b1;
        idle(4);
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_parity_err", int'(parity_err), 0);
        reset = 1'b0;
        idle(4);

        // First-frame latency measured from the falling start edge
        v0 = valid_cnt;
        k  = 0;
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;
`endif
        fork
            send_frame(8'h55, 1'b1);
            begin
                for (int n = 1; n <= LAT + 40; n++) begin
                    @(negedge clk);
                    if (valid && k == 0) k = n;
                end
            end
        join
        checks = checks + 1;
        if (k < LAT - 1 || k > LAT + 1) begin
            errors = errors + 1;
            $display("FAIL latency: got %0d cycles expected %0d +/-1", k, LAT);
        end
        idle(B);
        check("latency_valid_count", valid_cnt - v0, 1);
        check("latency_data", int'(data), 8'h55);

        // Short low glitch must be rejected
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(3 * B);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_frame_err", ferr_cnt - f0, 0);

        // Table of clean frames
        for (int i = 0; i < vecs.size(); i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            p0 = perr_cnt;
`ifdef UART_RX_PARITY_EN
            tx_par = vecs[i].par;
`endif
            send_frame(vecs[i].d, 1'b1);
            idle(2 * B);
            check($sformatf("vec%0d_valid", i), valid_cnt - v0, 1);
            check($sformatf("vec%0d_data", i), int'(data), int'(vecs[i].d));
            check($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, 0);
`ifdef UART_RX_PARITY_EN
            check($sformatf("vec%0d_parity_err", i), perr_cnt - p0, vecs[i].exp_perr);
`else
            check($sformatf("vec%0d_parity_err", i), perr_cnt - p0, 0);
`endif
        end

        // Stop bit low followed by a long break, then a good frame
        prev = vecs[vecs.size() - 1].d;
        v0 = valid_cnt;
        f0 = ferr_cnt;
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;
`endif
        send_frame(8'hA3, 1'b0);
        idle(300);
        check("break_frame_err", ferr_cnt - f0, 1);
        check("break_valid", valid_cnt - v0, 0);
        check("break_data_held", int'(data), int'(prev));
        rx = 1'b1;
        idle(2 * B);
        send_frame(8'h3C, 1'b1);
        idle(2 * B);
        check("after_break_valid", valid_cnt - v0, 1);
        check("after_break_data", int'(data), 8'h3C);
        check("after_break_frame_err", ferr_cnt - f0, 1);

        // Back-to-back frames with no idle gap
        v0 = valid_cnt;
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;
`endif
        send_frame(8'h00, 1'b1);
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;
`endif
        send_frame(8'hFF, 1'b1);
        idle(2 * B);
        check("b2b_valid", valid_cnt - v0, 2);
        if (valid_cnt - v0 == 2) begin
            check("b2b_first", int'(got[v0]), 8'h00);
            check("b2b_second", int'(got[v0 + 1]), 8'hFF);
        end

        // Reset during bit 4 of 0x81, then 0x7E
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        idle(B);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0) ? 1'b1 : 1'b0;
            idle(B);
        end
        rx = 1'b0;
        idle(H);
        reset = 1'b1;
        idle(3);
        check("midreset_data", int'(data), 0);
        check("midreset_valid", int'(valid), 0);
        rx = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(3 * B);
        check("midreset_no_pulse", valid_cnt - v0, 0);
        check("midreset_no_ferr", ferr_cnt - f0, 0);
        check("midreset_data_held", int'(data), 0);
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;
`endif
        send_frame(8'h7E, 1'b1);
        idle(2 * B);
        check("post_reset_valid", valid_cnt - v0, 1);
        check("post_reset_data", int'(data), 8'h7E);

        check("valid_frame_err_overlap", overlap_cnt, 0);
        check("parity_err_without_valid", stray_perr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 2605, meaning clock cycles per serial bit (19200 bps), legal range 4..8191.
REQ-002 SHALL derive HALF = BIT_CYCLES/2 (integer division, 1302 at default) as the start-bit mid-point offset.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8 data bits, LSB first.
REQ-006 SHALL have port data  output  8  last correctly framed byte.
REQ-007 SHALL have port valid  output  1  single-cycle pulse when data updates.
REQ-008 SHALL have port frame_err  output  1  single-cycle pulse when stop bit is sampled low.
REQ-009 SHALL have port parity_err  output  1  single-cycle pulse on parity mismatch, coincident with valid.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-012 IDLE: counter held at 0; rx_s==0 -> START.
REQ-013 START: counter increments each cycle; at count HALF-1 sample rx_s; 0 -> DATA with counter 0 and bit index 0; 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: at count BIT_CYCLES-1 sample rx_s into shift register MSB, shift right, counter to 0, bit index +1; after the 8th sample -> PARITY if enabled, else STOP.
REQ-015 PARITY: at count BIT_CYCLES-1 sample rx_s as parity bit, counter to 0 -> STOP.
REQ-016 STOP: at count BIT_CYCLES-1 sample rx_s; 1 -> load data from shift register, pulse valid the next cycle, -> IDLE; 0 -> pulse frame_err the next cycle, data unchanged, valid low, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx_s==1, then -> IDLE; a held-low break line SHALL produce exactly one frame_err.
REQ-018 Counter SHALL be 13 bits, never exceed BIT_CYCLES-1, and wrap to 0 only at the sampling points above.
REQ-019 valid, frame_err, parity_err SHALL be high for exactly one cycle per event and never simultaneously with frame_err.
REQ-020 data SHALL hold its value between valid pulses; no consumer handshake; an unread byte is overwritten by the next frame.
REQ-021 A new falling edge observed in IDLE the cycle after STOP SHALL start a new frame (back-to-back frames without gap supported).

Reset
REQ-022 reset SHALL force state IDLE, counter 0, bit index 0, shift register 0x00, data 0x00, valid 0, frame_err 0, parity_err 0, both synchronizer flops 1.
REQ-023 reset asserted mid-frame SHALL abandon the frame with no output pulse; reception resumes with the next falling edge after reset deasserts.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY state active, even parity expected; parity_err pulses with valid when XOR of 8 data bits and parity bit is 1; data still loaded.
REQ-025 Macro UART_RX_PARITY_EN undefined: PARITY state absent, frame is 8N1, parity_err tied to 0.

Verification
REQ-026 Default params, no parity: send 0x55 at 2605 cycles/bit -> one valid pulse, data=0x55, frame_err=0, valid 1302+9*2605=24747 cycles (±1) after START entry.
REQ-027 rx low pulse of 500 cycles then high -> no valid, no frame_err, state returns to IDLE.
REQ-028 send 0xA3 with stop bit forced low, line then held low 30000 cycles -> exactly one frame_err, data keeps previous value, next good frame 0x3C accepted.
REQ-029 two frames 0x00 then 0xFF back-to-back, zero idle gap -> two valid pulses, data 0x00 then 0xFF.
REQ-030 reset asserted during bit 4 of 0x81, then frame 0x7E -> no pulse for 0x81, valid with data=0x7E, data reads 0x00 during reset.
REQ-031 UART_RX_PARITY_EN defined: 0x07 with parity bit 0 -> valid with parity_err=1; with parity bit 1 -> valid, parity_err=0.
